branch_predict_ctrl: RTL

//  Branch prediction and redirect controller for the RV32I core. Holds a 2-bit

---
 rtl/branch_predict_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and redirect controller: 2-bit saturating BHT, mispredict redirect and front-end flush drain.
// Optional feature macro: BP_STATS_EN enables the branch/mispredict counters (ports tied to 0 otherwise).
//
// state    | meaning
// IDLE     | normal operation, resolutions train the BHT
// REDIRECT | one-cycle redirect pulse, front end flushed
// DRAIN    | flush held for FLUSH_CYCLES cycles, wrong-path resolutions ignored
module branch_predict_ctrl #(
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [31:0] branch_count,
    output logic [31:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [1:0]         bht_q [BHT_ENTRIES];
    logic [1:0]         bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0]   if_idx, ex_idx;
    logic [1:0]         ex_ctr;
    logic               res, mis;
    logic               unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_ctr = bht_q[ex_idx];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not visible.
    assign if_pred_taken = if_valid & bht_q[if_idx][1];

    assign res = ex_valid & ex_is_branch & (state_q == IDLE);
    assign mis = res & (ex_taken != ex_pred_taken);

    always_comb begin
        bht_d = bht_q;
        if (res) begin
            if (ex_taken)
                bht_d[ex_idx] = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
            else
                bht_d[ex_idx] = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (mis) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = ex_taken ? ex_target : ex_pc + 32'd4;
                end
            end
            REDIRECT: begin
                state_d = DRAIN;
                cnt_d   = CNT_INIT;
            end
            DRAIN: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            bht_q         <= bht_d;
        end
    end

    assign redirect_valid = (state_q == REDIRECT);
    assign flush          = (state_q != IDLE);
    assign busy           = (state_q != IDLE);
    assign redirect_pc    = redirect_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    always_comb begin
        branch_count_d  = branch_count_q + {31'd0, res};
        mispred_count_d = mispred_count_q + {31'd0, mis};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;
`else
    assign branch_count  = '0;
    assign mispred_count = '0;
`endif

endmodule
